// File: rtl/coherence_ctrl_n.sv
// Coherence/bus controller: arbitrates CPUS caches onto a single RAM port and runs
// instruction fetches, dirty writebacks, snoop broadcasts and memory or cache-to-cache fills.
module coherence_ctrl_n #(
   parameter int unsigned CPUS     = 2,
   parameter int unsigned BLKWORDS = 2,
   parameter int unsigned RR_EN    = 1
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [CPUS-1:0]      iREN,
   input  logic [CPUS-1:0]      dREN,
   input  logic [CPUS-1:0]      dWEN,
   input  logic [CPUS-1:0]      cctrans,
   input  logic [CPUS-1:0]      ccwrite,
   input  logic [CPUS*32-1:0]   iaddr,
   input  logic [CPUS*32-1:0]   daddr,
   input  logic [CPUS*32-1:0]   dstore,
   output logic [CPUS-1:0]      iwait,
   output logic [CPUS-1:0]      dwait,
   output logic [CPUS-1:0]      ccwait,
   output logic [CPUS-1:0]      ccinv,
   output logic [CPUS*32-1:0]   iload,
   output logic [CPUS*32-1:0]   dload,
   output logic [CPUS*32-1:0]   ccsnoopaddr,
   output logic                 ramREN,
   output logic                 ramWEN,
   output logic [31:0]          ramaddr,
   output logic [31:0]          ramstore,
   input  logic [31:0]          ramload,
   input  logic [1:0]           ramstate
);

   localparam int unsigned    PW       = (CPUS > 1) ? $clog2(CPUS) : 1;
   localparam int unsigned    WCW      = (BLKWORDS > 1) ? $clog2(BLKWORDS) : 1;
   localparam int unsigned    OFFW     = $clog2(BLKWORDS) + 2;
   localparam logic [31:0]    OFF_MASK = 32'((64'd1 << OFFW) - 64'd1);
   localparam logic [WCW-1:0] WLAST    = WCW'(BLKWORDS - 1);
   // RAM status encoding: FREE=0, BUSY=1, ACCESS=2, ERROR=3
   localparam logic [1:0]     ACCESS   = 2'd2;

   typedef enum logic [2:0] {IDLE, IFETCH, WB, SNOOP, SETTLE, MEMRD, C2C} state_t;

   state_t         state, nxt_state, gnt_state;
   logic [PW-1:0]  rr_ptr, nxt_rr, req, nxt_req, serv, nxt_serv;
   logic [PW-1:0]  gnt, dirty_idx;
   logic [WCW-1:0] wcnt, nxt_wcnt;
   logic           gnt_vld, dirty_vld, access;
   logic [CPUS-1:0] wb_vec;
   logic [31:0]    blk_base, word_addr;
   logic [31:0]    iaddr_a [CPUS];
   logic [31:0]    daddr_a [CPUS];
   logic [31:0]    dstore_a [CPUS];
   logic [31:0]    iload_a [CPUS];
   logic [31:0]    dload_a [CPUS];
   logic [31:0]    snoop_a [CPUS];
   logic [CPUS-1:0] unused_dren;

   // Read requests are implied by cctrans; dREN carries no extra information here.
   assign unused_dren = dREN;

   for (genvar k = 0; k < CPUS; k++) begin : g_port
      assign iaddr_a[k]             = iaddr[k*32 +: 32];
      assign daddr_a[k]             = daddr[k*32 +: 32];
      assign dstore_a[k]            = dstore[k*32 +: 32];
      assign iload[k*32 +: 32]       = iload_a[k];
      assign dload[k*32 +: 32]       = dload_a[k];
      assign ccsnoopaddr[k*32 +: 32] = snoop_a[k];
   end

   // Pick the requester closest at-or-after ptr (round robin) or the lowest index.
   function automatic logic [PW-1:0] arb(input logic [CPUS-1:0] v, input logic [PW-1:0] ptr);
      logic [PW-1:0] g;
      int unsigned   best, d;
      g    = '0;
      best = CPUS;
      for (int unsigned i = 0; i < CPUS; i++) begin
         d = (RR_EN != 0) ? (i + CPUS - 32'(ptr)) % CPUS : i;
         if (v[i] && d < best) begin
            best = d;
            g    = PW'(i);
         end
      end
      return g;
   endfunction

   assign access    = (ramstate == ACCESS);
   assign blk_base  = daddr_a[req] & ~OFF_MASK;
   assign word_addr = blk_base + (32'(wcnt) << 2);

   // Request class priority: writeback, then coherence miss, then instruction fetch.
   always_comb begin : arb_comb
      wb_vec    = dWEN & ~cctrans;
      gnt_vld   = 1'b1;
      gnt       = '0;
      gnt_state = IDLE;
      if (|wb_vec) begin
         gnt       = arb(wb_vec, rr_ptr);
         gnt_state = WB;
      end else if (|cctrans) begin
         gnt       = arb(cctrans, rr_ptr);
         gnt_state = dWEN[gnt] ? WB : SNOOP;
      end else if (|iREN) begin
         gnt       = arb(iREN, rr_ptr);
         gnt_state = IFETCH;
      end else begin
         gnt_vld   = 1'b0;
      end
   end

   // Lowest-index peer holding the block modified supplies it.
   always_comb begin : peer_scan
      dirty_vld = 1'b0;
      dirty_idx = '0;
      for (int unsigned k = 0; k < CPUS; k++) begin
         if (!dirty_vld && PW'(k) != req && ccwrite[k]) begin
            dirty_vld = 1'b1;
            dirty_idx = PW'(k);
         end
      end
   end

   always_ff @(posedge CLK) begin : state_reg
      if (RST) begin
         state  <= IDLE;
         rr_ptr <= '0;
         req    <= '0;
         serv   <= '0;
         wcnt   <= '0;
      end else begin
         state  <= nxt_state;
         rr_ptr <= nxt_rr;
         req    <= nxt_req;
         serv   <= nxt_serv;
         wcnt   <= nxt_wcnt;
      end
   end

   always_comb begin : fsm_comb
      nxt_state = state;
      nxt_rr    = rr_ptr;
      nxt_req   = req;
      nxt_serv  = serv;
      nxt_wcnt  = wcnt;
      iwait     = '1;
      dwait     = '1;
      ccwait    = '0;
      ccinv     = '0;
      ramREN    = 1'b0;
      ramWEN    = 1'b0;
      ramaddr   = '0;
      ramstore  = '0;
      for (int unsigned k = 0; k < CPUS; k++) begin
         iload_a[k] = '0;
         dload_a[k] = '0;
         snoop_a[k] = '0;
      end

      case (state)
         IDLE: begin
            if (gnt_vld) begin
               nxt_req   = gnt;
               nxt_rr    = (32'(gnt) == CPUS - 1) ? '0 : gnt + PW'(1);
               nxt_wcnt  = '0;
               nxt_state = gnt_state;
            end
         end

         IFETCH: begin
            ramREN       = 1'b1;
            ramaddr      = iaddr_a[req];
            iload_a[req] = ramload;
            iwait[req]   = ~access;
            if (access) nxt_state = IDLE;
         end

         WB: begin
            ramWEN     = 1'b1;
            ramaddr    = daddr_a[req];
            ramstore   = dstore_a[req];
            dwait[req] = ~access;
            if (access) begin
               if (wcnt == WLAST) nxt_state = cctrans[req] ? SNOOP : IDLE;
               else               nxt_wcnt  = wcnt + WCW'(1);
            end
         end

         SNOOP, SETTLE: begin
            for (int unsigned k = 0; k < CPUS; k++) begin
               if (PW'(k) != req) begin
                  ccwait[k]  = 1'b1;
                  ccinv[k]   = ccwrite[req];
                  snoop_a[k] = blk_base;
               end
            end
            if (state == SNOOP) begin
               nxt_state = SETTLE;
            end else begin
               nxt_wcnt = '0;
               if (dirty_vld) begin
                  nxt_serv  = dirty_idx;
                  nxt_state = C2C;
               end else begin
                  nxt_state = MEMRD;
               end
            end
         end

         MEMRD: begin
            ramREN       = 1'b1;
            ramaddr      = word_addr;
            dload_a[req] = ramload;
            dwait[req]   = ~access;
            if (access) begin
               if (wcnt == WLAST) nxt_state = IDLE;
               else               nxt_wcnt  = wcnt + WCW'(1);
            end
         end

         C2C: begin
            // Owner's data goes to the requester and is written back to RAM in the same beat.
            ramWEN        = 1'b1;
            ramaddr       = word_addr;
            ramstore      = dstore_a[serv];
            dload_a[req]  = dstore_a[serv];
            dwait[req]    = ~access;
            dwait[serv]   = ~access;
            ccwait[serv]  = 1'b1;
            snoop_a[serv] = word_addr;
            ccinv[serv]   = ccwrite[req];
            if (access) begin
               if (wcnt == WLAST) nxt_state = IDLE;
               else               nxt_wcnt  = wcnt + WCW'(1);
            end
         end

         default: nxt_state = IDLE;
      endcase
   end

endmodule

// File: tb/tb_coherence_ctrl_n.sv
// Testbench for coherence_ctrl_n: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_coherence_ctrl_n;
   localparam int         CPUS = 4;
   localparam int         BLK  = 2;
   localparam logic [1:0] ACC  = 2'd2;
   localparam logic [1:0] BSY  = 2'd1;

   logic         CLK = 1'b0;
   logic         RST;
   logic [3:0]   iREN, dREN, dWEN, cctrans, ccwrite;
   logic [127:0] iaddr, daddr, dstore;
   logic [3:0]   iwait, dwait, ccwait, ccinv;
   logic [127:0] iload, dload, ccsnoopaddr;
   logic         ramREN, ramWEN;
   logic [31:0]  ramaddr, ramstore, ramload;
   logic [1:0]   ramstate;

   coherence_ctrl_n #(.CPUS(CPUS), .BLKWORDS(BLK), .RR_EN(1)) dut (
      .CLK(CLK), .RST(RST), .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .cctrans(cctrans),
      .ccwrite(ccwrite), .iaddr(iaddr), .daddr(daddr), .dstore(dstore), .iwait(iwait),
      .dwait(dwait), .ccwait(ccwait), .ccinv(ccinv), .iload(iload), .dload(dload),
      .ccsnoopaddr(ccsnoopaddr), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
      .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
   );

   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   // Transaction-level model: who is being served and how far the transaction has got.
   bit m_busy  = 1'b0;
   bit m_fetch = 1'b0;
   int m_who   = 0;
   int m_wb_left, m_snp, m_src, m_fill;
   int m_rr    = 0;

   logic [3:0]   e_iwait, e_dwait, e_ccwait, e_ccinv;
   logic [127:0] e_iload, e_dload, e_snp;
   logic         e_ren, e_wen;
   logic [31:0]  e_raddr, e_rstore;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] sl(input logic [127:0] v, input int k);
      return v[k*32 +: 32];
   endfunction

   function automatic int pick(input logic [3:0] v);
      for (int i = 0; i < CPUS; i++) begin
         int idx;
         idx = (m_rr + i) % CPUS;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic model_outputs();
      logic        acc;
      logic [31:0] base, a;
      e_iwait = 4'hF; e_dwait = 4'hF; e_ccwait = 4'h0; e_ccinv = 4'h0;
      e_iload = '0; e_dload = '0; e_snp = '0;
      e_ren = 1'b0; e_wen = 1'b0; e_raddr = '0; e_rstore = '0;
      acc  = (ramstate == ACC);
      base = sl(daddr, m_who) & ~32'(BLK * 4 - 1);
      a    = base + 32'(4 * m_fill);
      if (!m_busy) return;
      if (m_fetch) begin
         e_ren = 1'b1; e_raddr = sl(iaddr, m_who);
         e_iload[m_who*32 +: 32] = ramload;
         e_iwait[m_who] = ~acc;
      end else if (m_wb_left > 0) begin
         e_wen = 1'b1; e_raddr = sl(daddr, m_who); e_rstore = sl(dstore, m_who);
         e_dwait[m_who] = ~acc;
      end else if (m_snp < 2) begin
         for (int k = 0; k < CPUS; k++)
            if (k != m_who) begin
               e_ccwait[k] = 1'b1;
               e_ccinv[k]  = ccwrite[m_who];
               e_snp[k*32 +: 32] = base;
            end
      end else if (m_src < 0) begin
         e_ren = 1'b1; e_raddr = a;
         e_dload[m_who*32 +: 32] = ramload;
         e_dwait[m_who] = ~acc;
      end else begin
         e_wen = 1'b1; e_raddr = a; e_rstore = sl(dstore, m_src);
         e_dload[m_who*32 +: 32] = sl(dstore, m_src);
         e_dwait[m_who] = ~acc;
         e_dwait[m_src] = ~acc;
         e_ccwait[m_src] = 1'b1;
         e_snp[m_src*32 +: 32] = a;
         e_ccinv[m_src] = ccwrite[m_who];
      end
   endtask

   // Model advance on each rising edge, from the inputs as they stand at the edge.
   initial forever begin
      @(posedge CLK);
      if (RST) begin
         m_busy = 1'b0;
         m_rr   = 0;
      end else if (!m_busy) begin
         int g;
         g = -1;
         if ((dWEN & ~cctrans) != 4'h0) begin
            g = pick(dWEN & ~cctrans); m_fetch = 1'b0; m_wb_left = BLK;
         end else if (cctrans != 4'h0) begin
            g = pick(cctrans); m_fetch = 1'b0; m_wb_left = dWEN[g] ? BLK : 0;
         end else if (iREN != 4'h0) begin
            g = pick(iREN); m_fetch = 1'b1; m_wb_left = 0;
         end
         if (g >= 0) begin
            m_busy = 1'b1; m_who = g; m_snp = 0; m_fill = 0; m_src = -1;
            m_rr = (g + 1) % CPUS;
         end
      end else if (m_fetch) begin
         if (ramstate == ACC) m_busy = 1'b0;
      end else if (m_wb_left > 0) begin
         if (ramstate == ACC) begin
            m_wb_left--;
            if (m_wb_left == 0 && !cctrans[m_who]) m_busy = 1'b0;
         end
      end else if (m_snp == 0) begin
         m_snp = 1;
      end else if (m_snp == 1) begin
         m_snp = 2;
         m_src = -1;
         for (int k = CPUS - 1; k >= 0; k--)
            if (k != m_who && ccwrite[k]) m_src = k;
      end else if (ramstate == ACC) begin
         m_fill++;
         if (m_fill == BLK) m_busy = 1'b0;
      end
   end

   // Every-cycle comparison of all outputs against the model.
   initial forever begin
      @(negedge CLK);
      if (chk_en) begin
         model_outputs();
         check("iwait", 128'(iwait), 128'(e_iwait));
         check("dwait", 128'(dwait), 128'(e_dwait));
         check("ccwait", 128'(ccwait), 128'(e_ccwait));
         check("ccinv", 128'(ccinv), 128'(e_ccinv));
         check("iload", iload, e_iload);
         check("dload", dload, e_dload);
         check("ccsnoopaddr", ccsnoopaddr, e_snp);
         check("ramREN", 128'(ramREN), 128'(e_ren));
         check("ramWEN", 128'(ramWEN), 128'(e_wen));
         check("ramaddr", 128'(ramaddr), 128'(e_raddr));
         check("ramstore", 128'(ramstore), 128'(e_rstore));
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_inputs();
      iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
      iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = 2'd0;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      clear_inputs();
      tick();
      tick();
      RST = 1'b0;
   endtask

   int gl[$];
   int exp_g[5] = '{0, 1, 2, 3, 0};

   initial begin
      RST = 1'b1;
      clear_inputs();
      do_reset();
      chk_en = 1'b1;

      // Idle outputs right after reset
      #1;
      check("rst_waits", 128'({iwait, dwait}), 128'(8'hFF));
      check("rst_cc", 128'({ccwait, ccinv}), 128'(0));
      check("rst_loads", iload | dload | ccsnoopaddr, 128'(0));
      check("rst_ram", 128'({ramREN, ramWEN, ramaddr, ramstore}), 128'(0));

      // Round-robin fetch sequence with all caches requesting
      for (int k = 0; k < CPUS; k++) iaddr[k*32 +: 32] = 32'h1000 + 32'(k * 16);
      iREN = 4'hF; ramstate = ACC; ramload = 32'h0000_1234;
      repeat (10) begin
         tick();
         #1;
         if (ramREN === 1'b1)
            for (int k = 0; k < CPUS; k++) if (iwait[k] === 1'b0) gl.push_back(k);
      end
      iREN = 4'h0;
      check("fetch_count", 128'(gl.size()), 128'(5));
      for (int i = 0; i < 5; i++)
         check($sformatf("grant%0d", i), 128'((i < gl.size()) ? gl[i] : -1), 128'(exp_g[i]));

      // Cache1 write miss, no dirty peers: invalidate others, fill from RAM
      do_reset();
      daddr[32 +: 32] = 32'h100; cctrans = 4'b0010; ccwrite = 4'b0010; ramstate = ACC;
      tick(); #1;
      check("s26_ccinv", 128'(ccinv), 128'(4'b1101));
      check("s26_ccwait", 128'(ccwait), 128'(4'b1101));
      check("s26_snp0", 128'(sl(ccsnoopaddr, 0)), 128'(32'h100));
      check("s26_dwait", 128'(dwait), 128'(4'hF));
      tick(); #1;
      check("s26_settle", 128'({ccinv, ramREN}), 128'(5'b11010));
      tick(); ramload = 32'hD00D_0001; #1;
      check("s26_rd0", 128'({ramREN, ramaddr}), 128'({1'b1, 32'h100}));
      check("s26_ld0", 128'({sl(dload, 1), dwait}), 128'({32'hD00D_0001, 4'b1101}));
      tick(); ramload = 32'hD00D_0002; cctrans = 4'b0000; #1;
      check("s26_rd1", 128'({ramREN, ramaddr}), 128'({1'b1, 32'h104}));
      tick(); #1;
      check("s26_idle", 128'(ramREN), 128'(0));

      // Cache0 miss served cache-to-cache by dirty cache2
      do_reset();
      daddr[0 +: 32] = 32'h200; cctrans = 4'b0001; ccwrite = 4'b0100;
      dstore[64 +: 32] = 32'hAAAA; ramstate = ACC;
      tick(); #1;
      check("s27_snoop", 128'({ccwait, ccinv}), 128'(8'b1110_0000));
      tick(); tick(); #1;
      check("s27_w0", 128'({ramWEN, ramREN, ramaddr, ramstore}),
            128'({1'b1, 1'b0, 32'h200, 32'hAAAA}));
      check("s27_ld0", 128'(sl(dload, 0)), 128'(32'hAAAA));
      check("s27_own0", 128'({ccwait, sl(ccsnoopaddr, 2)}), 128'({4'b0100, 32'h200}));
      tick(); dstore[64 +: 32] = 32'hBBBB; cctrans = 4'b0000; #1;
      check("s27_w1", 128'({ramaddr, ramstore, sl(dload, 0)}), 128'({32'h204, 32'hBBBB, 32'hBBBB}));
      tick(); #1;
      check("s27_idle", 128'(ramWEN), 128'(0));

      // Reset in the second C2C word; round-robin pointer must restart at 0
      do_reset();
      daddr[0 +: 32] = 32'h200; cctrans = 4'b0001; ccwrite = 4'b0100;
      dstore[64 +: 32] = 32'hAAAA; ramstate = ACC;
      tick(); tick(); tick(); tick(); RST = 1'b1; #1;
      check("s29_w1", 128'({ramWEN, ramaddr}), 128'({1'b1, 32'h204}));
      tick(); RST = 1'b0; cctrans = 4'b0000; ccwrite = 4'b0000;
      iREN = 4'b1001; iaddr[0 +: 32] = 32'hA0; iaddr[96 +: 32] = 32'hB0; ramstate = BSY; #1;
      check("s29_rst", 128'({ramWEN, dwait, ccwait}), 128'({1'b0, 4'hF, 4'h0}));
      tick(); #1;
      check("s29_rr0", 128'({ramREN, ramaddr}), 128'({1'b1, 32'hA0}));

      // Cache3 victim writeback followed by a miss filled from memory
      do_reset();
      daddr[96 +: 32] = 32'h300; dWEN = 4'b1000; cctrans = 4'b1000;
      dstore[96 +: 32] = 32'h5A; ramstate = ACC;
      tick(); #1;
      check("s28_wb0", 128'({ramWEN, ramaddr, dwait}), 128'({1'b1, 32'h300, 4'b0111}));
      tick(); daddr[96 +: 32] = 32'h304; #1;
      check("s28_wb1", 128'({ramWEN, ramaddr}), 128'({1'b1, 32'h304}));
      tick(); daddr[96 +: 32] = 32'h400; dWEN = 4'b0000; #1;
      check("s28_snoop", 128'({ccwait, sl(ccsnoopaddr, 0), ramREN, ramWEN}),
            128'({4'b0111, 32'h400, 2'b00}));
      tick(); tick(); #1;
      check("s28_rd0", 128'({ramREN, ramaddr}), 128'({1'b1, 32'h400}));
      tick(); cctrans = 4'b0000; #1;
      check("s28_rd1", 128'({ramREN, ramaddr}), 128'({1'b1, 32'h404}));
      tick(); #1;
      check("s28_idle", 128'(ramREN), 128'(0));

      // RAM stalls for five cycles in the middle of a memory fill
      do_reset();
      daddr[32 +: 32] = 32'h100; cctrans = 4'b0010; ramstate = ACC;
      tick(); tick();
      for (int i = 0; i < 5; i++) begin
         tick(); ramstate = BSY; #1;
         check($sformatf("s30_stall%0d", i), 128'({ramREN, ramaddr, dwait[1]}),
               128'({1'b1, 32'h100, 1'b1}));
      end
      tick(); ramstate = ACC; #1;
      check("s30_w0", 128'({ramaddr, dwait[1]}), 128'({32'h100, 1'b0}));
      tick(); cctrans = 4'b0000; #1;
      check("s30_w1", 128'({ramaddr, dwait[1]}), 128'({32'h104, 1'b0}));

      // Randomized traffic, including occasional resets
      do_reset();
      repeat (3000) begin
         tick();
         RST      = ($urandom_range(0, 199) == 0);
         iREN     = 4'($urandom) & 4'($urandom);
         dREN     = 4'($urandom);
         dWEN     = 4'($urandom) & 4'($urandom) & 4'($urandom);
         cctrans  = 4'($urandom) & 4'($urandom) & 4'($urandom);
         ccwrite  = 4'($urandom);
         for (int k = 0; k < CPUS; k++) begin
            iaddr[k*32 +: 32]  = $urandom;
            daddr[k*32 +: 32]  = $urandom;
            dstore[k*32 +: 32] = $urandom;
         end
         ramload  = $urandom;
         ramstate = 2'($urandom);
      end
      do_reset();
      tick();
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/coherence_ctrl_n.md
COHERENCE_CTRL_N -- requirements
Module: coherence_ctrl_n

Interface
REQ-001 SHALL have parameter CPUS, default 2, meaning number of cache ports (2..8).
REQ-002 SHALL have parameter BLKWORDS, default 2, meaning words per cache block (power of 2, 1..8).
REQ-003 SHALL have parameter RR_EN, default 1, meaning round-robin grant (1) or fixed lowest-index priority (0).
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 Ports:
  CLK  in  1  clock, all state changes on rising edge.
  RST  in  1  synchronous active-high reset.
  iREN, dREN, dWEN, cctrans, ccwrite  in  CPUS  per-cache request/status.
  iaddr, daddr, dstore  in  CPUS*32  per-cache address/data, slice k = cache k.
  iwait, dwait  out  CPUS  per-cache stall, 1 = wait.
  ccwait, ccinv  out  CPUS  snoop hold / invalidate.
  iload, dload, ccsnoopaddr  out  CPUS*32  per-cache return data / snoop address.
  ramREN, ramWEN  out  1  RAM strobes.
  ramaddr, ramstore  out  32  RAM address/data.
  ramload  in  32  RAM read data.
  ramstate  in  2  RAM status; ACCESS = word transfer completes this cycle.

Function
REQ-006 States SHALL be IDLE, IFETCH, WB, SNOOP, SETTLE, MEMRD, C2C.
REQ-007 In IDLE, request classes SHALL be served in priority order: dWEN without cctrans (writeback), then cctrans (coherence miss), then iREN.
REQ-008 Within a class, grant SHALL go to the first requester at or after rr_ptr, cyclically, when RR_EN=1. It SHALL go to the lowest index when RR_EN=0.
REQ-009 On grant, rr_ptr SHALL become grant+1 mod CPUS. req SHALL be latched and held until return to IDLE.
REQ-010 IFETCH SHALL drive ramREN=1 and ramaddr=iaddr[req]. When ramstate==ACCESS it SHALL drive iwait[req]=0 and iload[req]=ramload, then go to IDLE.
REQ-011 WB SHALL drive ramWEN=1, ramaddr=daddr[req], ramstore=dstore[req], and dwait[req]=(ramstate!=ACCESS).
REQ-012 In WB, a word counter wcnt SHALL increment on each ACCESS. After BLKWORDS words: if cctrans[req]=1, go to SNOOP; else go to IDLE.
REQ-013 SNOOP (1 cycle) SHALL drive, for every k!=req: ccwait[k]=1, ccsnoopaddr[k]=block base of daddr[req] (low log2(BLKWORDS)+2 bits cleared), ccinv[k]=ccwrite[req]. Next state is SETTLE.
REQ-014 SETTLE SHALL hold all SNOOP outputs and sample ccwrite of the other caches.
REQ-015 From SETTLE: if any other cache has ccwrite=1, latch the lowest such index as serv and go to C2C; else go to MEMRD.
REQ-016 MEMRD SHALL perform BLKWORDS reads at base+4*wcnt with ramREN=1. It SHALL return dload[req]=ramload with dwait[req]=(ramstate!=ACCESS), then go to IDLE.
REQ-017 C2C SHALL perform BLKWORDS words with:
  - ramWEN=1, ramaddr=base+4*wcnt, ramstore=dstore[serv];
  - dload[req]=dstore[serv];
  - dwait[req]=dwait[serv]=(ramstate!=ACCESS);
  - ccwait[serv]=1, ccsnoopaddr[serv]=base+4*wcnt, ccinv[serv]=ccwrite[req];
  then go to IDLE.
REQ-018 dwait[req] SHALL be 1 throughout SNOOP and SETTLE.
REQ-019 At most one of ramREN/ramWEN SHALL be asserted in any cycle.
REQ-020 Non-granted caches SHALL see iwait=dwait=1 and ccwait=0, unless they are snooped.
REQ-021 wcnt SHALL be log2(BLKWORDS) bits (min 1), clear on entry to WB/MEMRD/C2C, and never wrap mid-transfer.
REQ-022 Requests arriving outside IDLE SHALL be ignored until the next IDLE cycle. A request deasserted mid-transaction SHALL NOT abort it.

Reset
REQ-023 RST=1 at a rising edge SHALL force IDLE, rr_ptr=0, wcnt=0, req=0, serv=0, regardless of the current state (including mid-burst).
REQ-024 While in IDLE after reset, outputs SHALL be: iwait=dwait=all 1s; ccwait=ccinv=0; iload=dload=ccsnoopaddr=0; ramREN=ramWEN=0; ramaddr=ramstore=0.

Verification
REQ-025 CPUS=4, iREN=4'b1111, ramstate=ACCESS every cycle -> grants in order 0,1,2,3,0, one IFETCH per grant.
REQ-026 cache1 cctrans=1, daddr=0x100, ccwrite[1]=1, no dirty peers, BLKWORDS=2 -> ccinv=1 to caches 0,2,3; RAM reads 0x100, 0x104; go to IDLE.
REQ-027 cache0 miss at 0x200; cache2 ccwrite=1 with dstore 0xAAAA/0xBBBB -> C2C with serv=2; dload[0]=0xAAAA then 0xBBBB; RAM writes 0x200, 0x204.
REQ-028 cache3 dWEN+cctrans (victim 0x300, miss 0x400) -> WB 0x300/0x304, then SNOOP for 0x400, then MEMRD.
REQ-029 RST asserted in the second C2C word -> next cycle IDLE, ramWEN=0, all dwait=1.
REQ-030 ramstate held non-ACCESS for 5 cycles in MEMRD -> ramaddr stable, wcnt stable, dwait[req]=1 throughout.
